jtframe_vtiming_meter: RTL and testbench

- Measures the video timing produced by the frame timing generator: line length, active width, HS width, frame height, active lines and VS width.
- Sits directly downstream of the timing generator and taps the same pxl_cen, LHBL, LVBL, HS and VS signals.
- Publishes a consistent snapshot once per frame for the OSD/debug bus and for simulation checks.
- Purely observational: never drives video signals.

---
 rtl/jtframe_vtiming_meter.sv | 153 +++++++++++++++
 tb/tb_jtframe_vtiming_meter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_vtiming_meter.sv
// Passive video timing meter: measures line and frame geometry from the timing
// generator strobes and publishes one coherent snapshot per frame.
module jtframe_vtiming_meter #(
  parameter int W  = 10,
  parameter int FW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl_cen,
  input  logic          LHBL,
  input  logic          LVBL,
  input  logic          HS,
  input  logic          VS,
  output logic [W-1:0]  htotal,
  output logic [W-1:0]  hactive,
  output logic [W-1:0]  hs_width,
  output logic [W-1:0]  vtotal,
  output logic [W-1:0]  vactive,
  output logic [W-1:0]  vs_lines,
  output logic [FW-1:0] frames,
  output logic          upd,
  output logic          valid,
  output logic          stable,
  output logic          ovf
);
  localparam logic [W-1:0]  MAX = {W{1'b1}};
  localparam logic [W-1:0]  ONE = W'(1);
  localparam logic [FW-1:0] FONE = FW'(1);

  typedef enum logic {WAIT_VS, MEAS} state_t;
  state_t r_st, w_st_nx;

  logic         r_hs_l, r_vs_l;
  logic [W-1:0] r_pcnt, r_acnt, r_scnt;
  logic [W-1:0] r_hsh, r_ash, r_ssh;
  logic [W-1:0] r_lcnt, r_vacnt, r_vscnt;
  logic         r_ovf_acc;

  logic         w_hs_rise, w_vs_rise, w_pub, w_fclr;
  logic         w_psat, w_lsat, w_ovf_nx;
  logic [W-1:0] w_pcnt_nx, w_acnt_nx, w_scnt_nx;
  logic [W-1:0] w_hsh, w_ash, w_ssh;
  logic [W-1:0] w_lcnt, w_vacnt, w_vscnt;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v, input logic inc);
    return (inc && v != MAX) ? v + ONE : v;
  endfunction

  assign w_hs_rise = pxl_cen & HS & ~r_hs_l;
  assign w_vs_rise = pxl_cen & VS & ~r_vs_l;

  // An HS rise restarts the line counters with the current cen already counted
  assign w_pcnt_nx = w_hs_rise ? ONE : sat_inc(r_pcnt, 1'b1);
  assign w_acnt_nx = w_hs_rise ? {{(W-1){1'b0}}, LHBL} : sat_inc(r_acnt, LHBL);
  assign w_scnt_nx = w_hs_rise ? {{(W-1){1'b0}}, HS}   : sat_inc(r_scnt, HS);
  assign w_psat    = ~w_hs_rise & ((r_pcnt == MAX) | (LHBL & (r_acnt == MAX)) |
                                   (HS & (r_scnt == MAX)));

  // Line close folded in combinationally so a coincident VS rise publishes it
  assign w_hsh   = w_hs_rise ? r_pcnt : r_hsh;
  assign w_ash   = w_hs_rise ? r_acnt : r_ash;
  assign w_ssh   = w_hs_rise ? r_scnt : r_ssh;
  assign w_lcnt  = sat_inc(r_lcnt,  w_hs_rise);
  assign w_vacnt = sat_inc(r_vacnt, w_hs_rise & LVBL);
  assign w_vscnt = sat_inc(r_vscnt, w_hs_rise & VS);
  assign w_lsat  = w_hs_rise & ((r_lcnt == MAX) | (LVBL & (r_vacnt == MAX)) |
                                (VS & (r_vscnt == MAX)));

  assign w_ovf_nx = r_ovf_acc | w_psat | w_lsat;

  always_comb begin
    w_st_nx = r_st;
    w_pub   = 1'b0;
    w_fclr  = 1'b0;
    case (r_st)
      WAIT_VS: if (w_vs_rise) begin
        w_st_nx = MEAS;
        w_fclr  = 1'b1;
      end
      MEAS: if (w_vs_rise) begin
        w_pub  = 1'b1;
        w_fclr = 1'b1;
      end
      default: w_st_nx = WAIT_VS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st      <= WAIT_VS;
      r_hs_l    <= 1'b0;
      r_vs_l    <= 1'b0;
      r_pcnt    <= '0;
      r_acnt    <= '0;
      r_scnt    <= '0;
      r_hsh     <= '0;
      r_ash     <= '0;
      r_ssh     <= '0;
      r_lcnt    <= '0;
      r_vacnt   <= '0;
      r_vscnt   <= '0;
      r_ovf_acc <= 1'b0;
      htotal    <= '0;
      hactive   <= '0;
      hs_width  <= '0;
      vtotal    <= '0;
      vactive   <= '0;
      vs_lines  <= '0;
      frames    <= '0;
      upd       <= 1'b0;
      valid     <= 1'b0;
      stable    <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      r_st <= w_st_nx;
      upd  <= w_pub;
      if (pxl_cen) begin
        r_hs_l <= HS;
        r_vs_l <= VS;
        r_pcnt <= w_pcnt_nx;
        r_acnt <= w_acnt_nx;
        r_scnt <= w_scnt_nx;
        r_hsh  <= w_hsh;
        r_ash  <= w_ash;
        r_ssh  <= w_ssh;
        if (w_fclr) begin
          r_lcnt    <= '0;
          r_vacnt   <= '0;
          r_vscnt   <= '0;
          r_ovf_acc <= 1'b0;
        end else begin
          r_lcnt    <= w_lcnt;
          r_vacnt   <= w_vacnt;
          r_vscnt   <= w_vscnt;
          r_ovf_acc <= w_ovf_nx;
        end
        if (w_pub) begin
          htotal   <= w_hsh;
          hactive  <= w_ash;
          hs_width <= w_ssh;
          vtotal   <= w_lcnt;
          vactive  <= w_vacnt;
          vs_lines <= w_vscnt;
          frames   <= frames + FONE;
          valid    <= 1'b1;
          stable   <= (w_hsh == htotal) & (w_lcnt == vtotal) & valid;
          ovf      <= w_ovf_nx;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtframe_vtiming_meter.sv
// Bench for jtframe_vtiming_meter: frame-structured stimulus with a line/frame
// level reference model; a monitor pops expected snapshots on every upd pulse.
module tb_jtframe_vtiming_meter;
  localparam int W  = 10;
  localparam int FW = 8;
  localparam int MAXV = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst, pxl_cen, LHBL, LVBL, HS, VS;
  logic [W-1:0]  htotal, hactive, hs_width, vtotal, vactive, vs_lines;
  logic [FW-1:0] frames;
  logic upd, valid, stable, ovf;

  jtframe_vtiming_meter #(.W(W), .FW(FW)) dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .HS(HS), .VS(VS), .htotal(htotal), .hactive(hactive), .hs_width(hs_width),
    .vtotal(vtotal), .vactive(vactive), .vs_lines(vs_lines), .frames(frames),
    .upd(upd), .valid(valid), .stable(stable), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  ht, ha, hw, vt, va, vs;
    logic [FW-1:0] fr;
    logic          vld, stb, ovf;
  } exp_t;

  exp_t exp_q[$];
  int n_chk = 0, n_err = 0, n_upd = 0, n_push = 0;

  // Reference model state, kept in terms of lines and frames
  bit m_meas, m_pvalid;
  int m_prev_ht, m_prev_vt, m_frames;
  int l_len, l_act, l_hsw;         // last completed line
  int c_len, c_act, c_hsw;         // line in progress
  int n_lines, n_act, n_vs;        // current frame, unsaturated

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  task automatic model_reset();
    m_meas = 0; m_pvalid = 0; m_prev_ht = 0; m_prev_vt = 0; m_frames = 0;
    l_len = 0; l_act = 0; l_hsw = 0; c_len = 0; c_act = 0; c_hsw = 0;
    n_lines = 0; n_act = 0; n_vs = 0;
  endtask

  task automatic model_line(input bit lvbl, input bit vs);
    l_len = c_len; l_act = c_act; l_hsw = c_hsw;
    c_len = 0; c_act = 0; c_hsw = 0;
    n_lines++; n_act += int'(lvbl); n_vs += int'(vs);
  endtask

  task automatic model_vs();
    exp_t e;
    if (m_meas) begin
      e.ht  = W'(sat(l_len));
      e.ha  = W'(sat(l_act));
      e.hw  = W'(sat(l_hsw));
      e.vt  = W'(sat(n_lines));
      e.va  = W'(sat(n_act));
      e.vs  = W'(sat(n_vs));
      e.fr  = FW'((m_frames + 1) % (1 << FW));
      e.vld = 1'b1;
      e.stb = m_pvalid && sat(l_len) == m_prev_ht && sat(n_lines) == m_prev_vt;
      e.ovf = (n_lines > MAXV) || (n_act > MAXV) || (n_vs > MAXV) ||
              (l_len > MAXV);
      exp_q.push_back(e);
      n_push++;
      m_prev_ht = sat(l_len); m_prev_vt = sat(n_lines);
      m_pvalid = 1; m_frames++;
    end
    n_lines = 0; n_act = 0; n_vs = 0;
    m_meas = 1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_htotal"},   htotal,   0);
    chk({tag, "_hactive"},  hactive,  0);
    chk({tag, "_hs_width"}, hs_width, 0);
    chk({tag, "_vtotal"},   vtotal,   0);
    chk({tag, "_vactive"},  vactive,  0);
    chk({tag, "_vs_lines"}, vs_lines, 0);
    chk({tag, "_frames"},   frames,   0);
    chk({tag, "_upd"},      upd,      0);
    chk({tag, "_valid"},    valid,    0);
    chk({tag, "_stable"},   stable,   0);
    chk({tag, "_ovf"},      ovf,      0);
  endtask

  task automatic cen(input logic hs, input logic lhbl, input logic lvbl,
                     input logic vs, input int gap);
    HS = hs; LHBL = lhbl; LVBL = lvbl; VS = vs; pxl_cen = 1'b1;
    @(negedge clk);
    pxl_cen = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  // One frame: VS rises in line 0 at cen offset voff and stays high for vsn
  // lines; LVBL covers vact lines ending one line before the frame ends.
  task automatic frame(input int nl, input int len, input int act, input int hsw,
                       input int vact, input int vsn, input int voff,
                       input int gap, input int rst_line);
    int vstart;
    bit hs, lh, lv, vs;
    vstart = nl - vact - 1;
    for (int l = 0; l < nl; l++) begin
      lv = (l >= vstart) && (l < vstart + vact);
      for (int c = 0; c < len; c++) begin
        hs = c < hsw;
        lh = c >= len - act;
        vs = (l == 0 && c >= voff) || (l >= 1 && l < vsn) || (l == vsn && c < voff);
        if (l == rst_line && c == len / 2) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          model_reset();
          chk_zero("midrst");
          chk("midrst_pending", exp_q.size(), 0);
        end
        if (c == 0) model_line(lv, vs);
        if (l == 0 && c == voff) model_vs();
        cen(hs, lh, lv, vs, gap);
        c_len++; c_act += int'(lh); c_hsw += int'(hs);
      end
    end
  endtask

  // Scoreboard monitor
  bit prev_upd = 0;
  exp_t me;
  initial begin
    forever begin
      @(negedge clk);
      if (prev_upd) chk("upd_pulse", upd, 0);
      if (upd) begin
        n_upd++;
        if (exp_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_upd: got upd=1 expected no publication");
        end else begin
          me = exp_q.pop_front();
          chk("htotal",   htotal,   me.ht);
          chk("hactive",  hactive,  me.ha);
          chk("hs_width", hs_width, me.hw);
          chk("vtotal",   vtotal,   me.vt);
          chk("vactive",  vactive,  me.va);
          chk("vs_lines", vs_lines, me.vs);
          chk("frames",   frames,   me.fr);
          chk("valid",    valid,    me.vld);
          chk("stable",   stable,   me.stb);
          chk("ovf",      ovf,      me.ovf);
        end
      end
      prev_upd = upd;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1);
  end

  // Scaled-down geometry (1/8 of 384x264) keeps the run short
  localparam int SL = 48, SA = 40, SH = 3, SN = 33, SV = 28, SVS = 3;

  initial begin
    int nl, len, act, hsw, vsn, vact, voff, gap;
    rst = 1'b1; pxl_cen = 1'b0; LHBL = 1'b0; LVBL = 1'b0; HS = 1'b0; VS = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    model_reset();

    repeat (3) frame(SN, SL, SA, SH, SV, SVS, 20, 2, -1);
    frame(SN, SL - 1, SA, SH, SV, SVS, 20, 2, -1);
    repeat (2) frame(SN, SL, SA, SH, SV, SVS, 20, 2, -1);
    frame(1100, 6, 4, 2, SV, SVS, 3, 2, -1);
    frame(SN, SL, SA, SH, SV, SVS, 20, 2, -1);
    repeat (2) frame(SN, SL, SA, SH, SV, SVS, 0, 2, -1);
    frame(SN, SL, SA, SH, SV, SVS, 0, 2, 15);
    repeat (2) frame(SN, SL, SA, SH, SV, SVS, 20, 2, -1);

    repeat (4) begin
      len  = 30 + int'($urandom % 51);
      act  = 10 + int'($urandom % (len - 20));
      hsw  = 1 + int'($urandom % 8);
      nl   = 20 + int'($urandom % 21);
      vsn  = 1 + int'($urandom % 4);
      vact = int'($urandom % (nl - vsn - 1));
      voff = ($urandom % 2 == 0) ? 0 : 1 + int'($urandom % (len - 1));
      gap  = 1 + int'($urandom % 3);
      frame(nl, len, act, hsw, vact, vsn, voff, gap, -1);
    end
    frame(SN, SL, SA, SH, SV, SVS, 20, 2, -1);

    repeat (4) @(negedge clk);
    chk("pending_expect", exp_q.size(), 0);
    chk("pub_count", n_upd, n_push);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
